// File: rtl/ascon_io_pkg.sv
// Shared types and sizing helpers for the Ascon serial I/O front end.
// Beat counts are derived from stream lengths and lane width via calc_ni/calc_no.
package ascon_io_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    LOADED = 2'd2,
    UNLOAD = 2'd3
  } io_state_t;

  localparam int BEAT_W  = 16;
  localparam int DIR_IN  = 0;
  localparam int DIR_OUT = 1;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int calc_ni(input int k_len, input int l_len, input int y_len, input int w);
    return ceil_div(max_int(max_int(k_len, 128), max_int(l_len, y_len)), w);
  endfunction

  function automatic int calc_no(input int y_len, input int w);
    return ceil_div(max_int(y_len, 128), w);
  endfunction

endpackage

// File: rtl/ascon_lane_shifter.sv
// One stream's W-bit lane shift register: assembles a LEN-bit value (DIR_IN) or emits one (DIR_OUT).
// Bit order follows ASCON_IO_LSB_FIRST_EN (defined: LSB first, undefined: MSB first).
module ascon_lane_shifter
  import ascon_io_pkg::*;
#(
  parameter int LEN = 40,
  parameter int W   = 1,
  parameter int DIR = DIR_IN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LEN-1:0]    value,
  input  logic              en,
  input  logic [BEAT_W-1:0] beat,
  input  logic [W-1:0]      lane_in,
  output logic [LEN-1:0]    data,
  output logic [W-1:0]      lane_out
);

  localparam int NB = ceil_div(LEN, W);
  // Lane bits actually carrying data on the stream's final beat.
  localparam int R  = LEN - (NB - 1) * W;

  logic [LEN-1:0]   data_r;
  logic [LEN-1:0]   full_s;
  logic [LEN-1:0]   part_s;
  logic [LEN+W-1:0] wide_s;
  logic [LEN+R-1:0] wide_part_s;
  logic             unused_s;

  assign data = data_r;

  generate
    if (DIR == DIR_IN) begin : g_in
`ifdef ASCON_IO_LSB_FIRST_EN
      assign wide_s      = {lane_in, data_r};
      assign wide_part_s = {lane_in[R-1:0], data_r};
      assign full_s      = wide_s[LEN+W-1:W];
      assign part_s      = wide_part_s[LEN+R-1:R];
`else
      assign wide_s      = {data_r, lane_in};
      assign wide_part_s = {data_r, lane_in[W-1 -: R]};
      assign full_s      = wide_s[LEN-1:0];
      assign part_s      = wide_part_s[LEN-1:0];
`endif
      assign lane_out = {W{1'b0}};
      assign unused_s = ^{wide_s, wide_part_s};

      // Capture accepted beats; beats past the stream end leave the value untouched.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_r <= {LEN{1'b0}};
        end else if (load) begin
          data_r <= value;
        end else if (en && (beat < BEAT_W'(NB - 1))) begin
          data_r <= full_s;
        end else if (en && (beat == BEAT_W'(NB - 1))) begin
          data_r <= part_s;
        end else begin
          data_r <= data_r;
        end
      end
    end else begin : g_out
      // Zeros shift in behind the data, so partial and past-end beats read 0.
`ifdef ASCON_IO_LSB_FIRST_EN
      assign wide_s   = {{W{1'b0}}, data_r};
      assign lane_out = wide_s[W-1:0];
      assign full_s   = wide_s[LEN+W-1:W];
`else
      assign wide_s   = {data_r, {W{1'b0}}};
      assign lane_out = wide_s[LEN+W-1 -: W];
      assign full_s   = wide_s[LEN-1:0];
`endif
      assign part_s      = {LEN{1'b0}};
      assign wide_part_s = {(LEN+R){1'b0}};
      assign unused_s    = ^{wide_s, wide_part_s, part_s, lane_in};

      // Parallel capture, then advance one beat per accepted output.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_r <= {LEN{1'b0}};
        end else if (load) begin
          data_r <= value;
        end else if (en && (beat < BEAT_W'(NB))) begin
          data_r <= full_s;
        end else begin
          data_r <= data_r;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/ascon_serial_io.sv
// Ascon serial I/O front end: four input lanes deserialised under in_valid/in_ready,
// ciphertext and tag serialised under out_valid/out_ready. Option: ASCON_IO_LSB_FIRST_EN.
module ascon_serial_io
  import ascon_io_pkg::*;
#(
  parameter int k = 128,
  parameter int l = 40,
  parameter int y = 40,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] key_in,
  input  logic [W-1:0] nonce_in,
  input  logic [W-1:0] ad_in,
  input  logic [W-1:0] pt_in,
  output logic [k-1:0] key,
  output logic [127:0] nonce,
  output logic [l-1:0] associated_data,
  output logic [y-1:0] plain_text,
  output logic         load_done,
  input  logic         unload_start,
  input  logic [y-1:0] ct_par,
  input  logic [127:0] tag_par,
  output logic [W-1:0] ct_out,
  output logic [W-1:0] tag_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         unload_done
);

  localparam int NI = calc_ni(k, l, y, W);
  localparam int NO = calc_no(y, W);

  io_state_t         state_r;
  io_state_t         state_s;
  logic [BEAT_W-1:0] in_beat_r;
  logic [BEAT_W-1:0] out_beat_r;
  logic              start_load_s;
  logic              start_unload_s;
  logic              in_fire_s;
  logic              out_fire_s;

  logic [W-1:0]   unused_key_lane_s;
  logic [W-1:0]   unused_nonce_lane_s;
  logic [W-1:0]   unused_ad_lane_s;
  logic [W-1:0]   unused_pt_lane_s;
  logic [y-1:0]   unused_ct_data_s;
  logic [127:0]   unused_tag_data_s;

  // Next-state and handshake decode.
  always_comb begin
    state_s        = state_r;
    start_load_s   = 1'b0;
    start_unload_s = 1'b0;
    in_fire_s      = 1'b0;
    out_fire_s     = 1'b0;
    load_done      = 1'b0;
    unload_done    = 1'b0;
    case (state_r)
      IDLE, LOADED: begin
        if (load_start) begin
          state_s      = LOAD;
          start_load_s = 1'b1;
        end else if (unload_start) begin
          state_s        = UNLOAD;
          start_unload_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      LOAD: begin
        if (in_valid) begin
          in_fire_s = 1'b1;
          if (in_beat_r == BEAT_W'(NI - 1)) begin
            load_done = 1'b1;
            state_s   = LOADED;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      UNLOAD: begin
        if (out_ready) begin
          out_fire_s = 1'b1;
          if (out_beat_r == BEAT_W'(NO - 1)) begin
            unload_done = 1'b1;
            state_s     = IDLE;
          end else begin
            state_s = UNLOAD;
          end
        end else begin
          state_s = UNLOAD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  assign in_ready  = (state_r == LOAD);
  assign out_valid = (state_r == UNLOAD);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Beat counters restart on every new transfer and after its final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_beat_r  <= {BEAT_W{1'b0}};
      out_beat_r <= {BEAT_W{1'b0}};
    end else begin
      if (start_load_s || load_done) begin
        in_beat_r <= {BEAT_W{1'b0}};
      end else if (in_fire_s) begin
        in_beat_r <= in_beat_r + BEAT_W'(1);
      end else begin
        in_beat_r <= in_beat_r;
      end
      if (start_unload_s || unload_done) begin
        out_beat_r <= {BEAT_W{1'b0}};
      end else if (out_fire_s) begin
        out_beat_r <= out_beat_r + BEAT_W'(1);
      end else begin
        out_beat_r <= out_beat_r;
      end
    end
  end

  ascon_lane_shifter #(.LEN(k), .W(W), .DIR(DIR_IN)) u_key (
    .clk(clk), .rst(rst), .load(start_load_s), .value({k{1'b0}}), .en(in_fire_s),
    .beat(in_beat_r), .lane_in(key_in), .data(key), .lane_out(unused_key_lane_s)
  );

  ascon_lane_shifter #(.LEN(128), .W(W), .DIR(DIR_IN)) u_nonce (
    .clk(clk), .rst(rst), .load(start_load_s), .value({128{1'b0}}), .en(in_fire_s),
    .beat(in_beat_r), .lane_in(nonce_in), .data(nonce), .lane_out(unused_nonce_lane_s)
  );

  ascon_lane_shifter #(.LEN(l), .W(W), .DIR(DIR_IN)) u_ad (
    .clk(clk), .rst(rst), .load(start_load_s), .value({l{1'b0}}), .en(in_fire_s),
    .beat(in_beat_r), .lane_in(ad_in), .data(associated_data), .lane_out(unused_ad_lane_s)
  );

  ascon_lane_shifter #(.LEN(y), .W(W), .DIR(DIR_IN)) u_pt (
    .clk(clk), .rst(rst), .load(start_load_s), .value({y{1'b0}}), .en(in_fire_s),
    .beat(in_beat_r), .lane_in(pt_in), .data(plain_text), .lane_out(unused_pt_lane_s)
  );

  ascon_lane_shifter #(.LEN(y), .W(W), .DIR(DIR_OUT)) u_ct (
    .clk(clk), .rst(rst), .load(start_unload_s), .value(ct_par), .en(out_fire_s),
    .beat(out_beat_r), .lane_in({W{1'b0}}), .data(unused_ct_data_s), .lane_out(ct_out)
  );

  ascon_lane_shifter #(.LEN(128), .W(W), .DIR(DIR_OUT)) u_tag (
    .clk(clk), .rst(rst), .load(start_unload_s), .value(tag_par), .en(out_fire_s),
    .beat(out_beat_r), .lane_in({W{1'b0}}), .data(unused_tag_data_s), .lane_out(tag_out)
  );

endmodule
